// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller signal bundle: pipeline hazard inputs and sequencing outputs.
// The master modport is the controller; the slave modport is the pipeline side.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic                 ex_memRead;
  logic [4:0]           ex_rd;
  logic                 ex_redirect;
  logic                 ex_mc_op;
  logic                 mc_done;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 pc_en;
  logic                 ifid_en;
  logic                 idex_en;
  logic                 exmem_en;
  logic                 memwb_en;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 exmem_flush;
  logic                 mc_start;
  logic [CNT_WIDTH-1:0] stall_cnt;

  modport master (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_rd,
    input  ex_redirect, ex_mc_op, mc_done, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, mc_start, stall_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_rd,
    output ex_redirect, ex_mc_op, mc_done, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, mc_start, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: resolves load-use, redirect, multi-cycle and memory-wait hazards
// with combinational enables/flushes, and counts stalled cycles in a saturating counter.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rstN,
  hazard_stall_ctrl_if.master bus
);

  typedef enum logic [1:0] {StRun, StMcWait, StMcHold} state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 freeze, load_use;
  logic                 pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic                 ifid_flush_c, idex_flush_c, exmem_flush_c, mc_start_c;

  assign freeze   = bus.mem_req & ~bus.mem_ready;
  assign load_use = bus.ex_memRead & (bus.ex_rd != 5'd0) &
                    ((bus.id_use_rs1 & (bus.ex_rd == bus.id_rs1)) |
                     (bus.id_use_rs2 & (bus.ex_rd == bus.id_rs2)));

  always_comb begin
    state_d       = state_q;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    memwb_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    mc_start_c    = 1'b0;
    if (!rstN) begin
      state_d = StRun;
    end else if (freeze) begin
      // Memory wait freezes everything; a done pulse seen now must not be lost.
      if (state_q == StMcWait && bus.mc_done) state_d = StMcHold;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.ex_redirect) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
          end else if (bus.ex_mc_op) begin
            mc_start_c    = 1'b1;
            exmem_en_c    = 1'b1;
            exmem_flush_c = 1'b1;
            memwb_en_c    = 1'b1;
            state_d       = StMcWait;
          end else if (load_use) begin
            idex_en_c    = 1'b1;
            idex_flush_c = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
          end else begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
          end
        end
        StMcWait: begin
          if (bus.mc_done) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
            state_d = StRun;
          end else begin
            exmem_en_c    = 1'b1;
            exmem_flush_c = 1'b1;
            memwb_en_c    = 1'b1;
          end
        end
        StMcHold: begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!pc_en_c && cnt_q != CntMax) cnt_q <= cnt_q + CntOne;
    end
  end

  assign bus.pc_en       = pc_en_c;
  assign bus.ifid_en     = ifid_en_c;
  assign bus.idex_en     = idex_en_c;
  assign bus.exmem_en    = exmem_en_c;
  assign bus.memwb_en    = memwb_en_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_flush  = idex_flush_c;
  assign bus.exmem_flush = exmem_flush_c;
  assign bus.mc_start    = mc_start_c;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: hand-computed enables, flushes and stall counts,
// plus a 4-bit counter instance for saturation.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_WIDTH(32)) bus ();
  hazard_stall_ctrl_if #(.CNT_WIDTH(4))  bus4 ();

  hazard_stall_ctrl #(.CNT_WIDTH(32)) dut (.clk(clk), .rstN(rstN), .bus(bus));
  hazard_stall_ctrl #(.CNT_WIDTH(4))  dut4 (.clk(clk), .rstN(rstN), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = 5'd0;  bus.id_rs2 = 5'd0;  bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_memRead = 1'b0; bus.ex_rd = 5'd0; bus.ex_redirect = 1'b0; bus.ex_mc_op = 1'b0;
    bus.mc_done = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  // Packs {pc,ifid,idex,exmem,memwb} enables for compact comparison.
  function automatic logic [4:0] ens();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
  endfunction

  function automatic logic [2:0] flushes();
    return {bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    bus4.id_rs1 = 5'd0;  bus4.id_rs2 = 5'd0;  bus4.id_use_rs1 = 1'b0; bus4.id_use_rs2 = 1'b0;
    bus4.ex_memRead = 1'b0; bus4.ex_rd = 5'd0; bus4.ex_redirect = 1'b0; bus4.ex_mc_op = 1'b0;
    bus4.mc_done = 1'b0; bus4.mem_req = 1'b0; bus4.mem_ready = 1'b0;

    // Reset held: everything quiet, counter zero.
    @(negedge clk);
    check("rst_ens", ens(), 5'b00000);
    check("rst_flush", flushes(), 3'b000);
    check("rst_cnt", bus.stall_cnt, 0);
    tick();
    rstN = 1'b1;
    @(negedge clk);
    check("idle_ens", ens(), 5'b11111);
    tick();

    // Load x5 in EX, ID reads rs2 = x5.
    bus.ex_memRead = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
    @(negedge clk);
    check("lu_ens", ens(), 5'b00111);
    check("lu_flush", flushes(), 3'b010);
    tick();
    clear_inputs();
    @(negedge clk);
    check("lu_after_ens", ens(), 5'b11111);
    check("lu_cnt", bus.stall_cnt, 1);
    tick();

    // Load to x0 and unused-source cases never stall.
    bus.ex_memRead = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
    @(negedge clk);
    check("x0_ens", ens(), 5'b11111);
    tick();
    clear_inputs();
    bus.ex_memRead = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b0;
    @(negedge clk);
    check("unused_ens", ens(), 5'b11111);
    check("unused_flush", flushes(), 3'b000);
    tick();

    // Redirect wins over load-use.
    bus.ex_redirect = 1'b1; bus.id_use_rs1 = 1'b1;
    @(negedge clk);
    check("redir_ens", ens(), 5'b11111);
    check("redir_flush", flushes(), 3'b110);
    tick();
    clear_inputs();
    @(negedge clk);
    check("redir_cnt", bus.stall_cnt, 1);
    tick();

    // Multi-cycle op: start, 4 wait cycles, done on the 6th cycle.
    bus.ex_mc_op = 1'b1;
    @(negedge clk);
    check("mc_start", bus.mc_start, 1);
    check("mc0_ens", ens(), 5'b00011);
    check("mc0_flush", flushes(), 3'b001);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mcw%0d_start", i), bus.mc_start, 0);
      check($sformatf("mcw%0d_ens", i), ens(), 5'b00011);
      check($sformatf("mcw%0d_flush", i), flushes(), 3'b001);
      tick();
    end
    bus.mc_done = 1'b1;
    @(negedge clk);
    check("mcdone_ens", ens(), 5'b11111);
    check("mcdone_flush", flushes(), 3'b000);
    tick();
    clear_inputs();
    @(negedge clk);
    check("mc_run_ens", ens(), 5'b11111);
    check("mc_cnt", bus.stall_cnt, 6);
    tick();

    // Done pulse during a memory wait moves to hold; release resumes without restarting.
    bus.ex_mc_op = 1'b1;
    tick();
    tick();
    bus.mc_done = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk);
    check("frz_done_ens", ens(), 5'b00000);
    check("frz_done_flush", flushes(), 3'b000);
    tick();
    bus.mc_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_ens", i), ens(), 5'b00000);
      check($sformatf("hold%0d_start", i), bus.mc_start, 0);
      tick();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("hold_rel_ens", ens(), 5'b11111);
    check("hold_rel_start", bus.mc_start, 0);
    tick();
    clear_inputs();
    @(negedge clk);
    check("hold_run_ens", ens(), 5'b11111);
    check("hold_cnt", bus.stall_cnt, 11);
    tick();

    // Reset while waiting on a multi-cycle op.
    bus.ex_mc_op = 1'b1;
    tick();
    #2;
    rstN = 1'b0;
    #1;
    check("mrst_ens", ens(), 5'b00000);
    check("mrst_flush", flushes(), 3'b000);
    check("mrst_cnt", bus.stall_cnt, 0);
    clear_inputs();
    tick();
    rstN = 1'b1;
    @(negedge clk);
    check("mrst_run_ens", ens(), 5'b11111);
    tick();
    check("mrst_cnt_after", bus.stall_cnt, 0);

    // 4-bit counter saturates at 15 under a long memory wait.
    bus4.mem_req = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", {28'd0, bus4.stall_cnt}, 14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_15", {28'd0, bus4.stall_cnt}, 15);
    bus4.mem_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
